mem_stage: RTL
==============

Name: mem_stage

Overview:
Pipeline MEM stage. It consumes the EX stage's ALU result (the effective address) and its forwarded store operand, together with the control bits carried in the EX/MEM register. It runs a request/acknowledge handshake with the data memory, performs byte/half/word lane steering and load extension, and registers the result into the MEM/WB register. It stalls the upstream pipeline while an access is outstanding. Its registered writeback value is the MEM_WB_Data source used by EX-stage forwarding.

Parameters:
TIMEOUT, 16, maximum cycles in ACCESS without dmem_ack before the access is aborted with a bus fault.

Ports:
clk  input  1  pipeline clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  the EX/MEM slot holds a real instruction
MemRead  input  1  load
MemWrite  input  1  store
RegWrite  input  1  instruction writes rd
MemtoReg  input  1  writeback selects load data
Funct3  input  3  access size and sign
ALUResult  input  32  effective address, or the ALU result for non-memory instructions
StoreData  input  32  forwarded rs2 value for stores
Rd_in  input  5  destination register
dmem_rdata  input  32  read word from data memory
dmem_ack  input  1  access complete; rdata valid this cycle for reads
dmem_req  output  1  access request, held high until ack
dmem_we  output  1  write request
dmem_addr  output  32  word-aligned address ({ALUResult[31:2],2'b00})
dmem_wdata  output  32  store data replicated onto the lanes
dmem_wstrb  output  4  byte write enables
stall  output  1  upstream stages must hold
mem_fault  output  1  one-cycle fault pulse
fault_cause  output  2  01 misaligned, 10 timeout, 11 illegal Funct3; valid while mem_fault is high
MEM_WB_RegWrite  output  1  registered
MEM_WB_MemtoReg  output  1  registered
MEM_WB_Rd  output  5  registered
MEM_WB_Data  output  32  registered final writeback value

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0, state is IDLE and the timeout counter is 0. Asserting rst mid-access abandons the access immediately, with no fault and no writeback.
- A memory op is in_valid & (MemRead | MemWrite). Legal loads: Funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- States: IDLE and ACCESS.
- IDLE, non-memory op: on the next edge MEM_WB takes RegWrite, MemtoReg, Rd_in and Data=ALUResult. stall=0.
- IDLE, memory op, legal and aligned: stall=1 combinationally. Next state is ACCESS and the counter is cleared. dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_wstrb are registered on that edge and therefore first visible in ACCESS.
- IDLE, memory op, illegal or misaligned: no request is issued and stall=0. On the next edge mem_fault=1 with the matching cause, and a bubble enters MEM_WB (RegWrite=0). Illegal takes priority over misaligned.
- ACCESS: dmem_req=1 and stall = ~dmem_ack.
  - On dmem_ack: for loads, MEM_WB_Data = the extended load; for stores, RegWrite is forced to 0. dmem_req drops and the state returns to IDLE on that edge.
  - While waiting for ack, MEM_WB receives a bubble (RegWrite=0) every cycle.
- Timeout: if the counter reaches TIMEOUT-1 without ack, on that edge mem_fault=1 with cause 10, a bubble enters MEM_WB, dmem_req drops, the state returns to IDLE and stall=0. An ack arriving in the same cycle wins; no fault is raised.
- Load extraction uses byte lane addr[1:0] (LB/LBU) or half lane addr[1] (LH/LHU). LB/LH sign-extend; LBU/LHU zero-extend.
- Store steering:
  - SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{half}}, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wstrb = 1111.
- mem_fault is exactly one cycle wide. fault_cause holds its value until the next fault.
- Upstream inputs are held stable while stall=1. The block does not re-sample them mid-access.

Test Plan:
- Non-memory op: ALUResult=0x0000_0042, Rd=5, RegWrite=1 → next edge MEM_WB_Data=0x42, MEM_WB_Rd=5, stall=0, dmem_req never asserted.
- LW from 0x100, memory acks 2 cycles after req with 0xDEAD_BEEF → stall high for 3 cycles, then MEM_WB_Data=0xDEADBEEF, RegWrite=1 on the ack edge; the two wait cycles show RegWrite=0.
- LB/LBU from addr 0x103 with rdata 0x80FF_FF7F, and LH/LHU from 0x102 → LB=0xFFFF_FF80, LBU=0x0000_0080, LH=0xFFFF_80FF, LHU=0x0000_80FF.
- SB 0x12345678 to 0x201 → dmem_addr=0x200, wstrb=0010, wdata=0x78787878, MEM_WB_RegWrite=0; SH to 0x202 → wstrb=1100, wdata=0x56785678.
- LW from 0x102 → no dmem_req, mem_fault=1 for one cycle, cause=01. Funct3=011 on a load → cause=11.
- Ack withheld with TIMEOUT=16 → fault cause=10 after 16 ACCESS cycles, stall released, req dropped. Repeat with rst pulsed at ACCESS cycle 3 → all outputs 0, no fault.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage.
//
// Takes the EX/MEM slot (effective address, forwarded store operand and control bits).
// It runs a req/ack handshake with data memory, with a bounded wait, and steers store
// lanes. Loads are extracted and extended. The result is registered into MEM/WB.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid                 EX/MEM slot holds a real instruction
//   MemRead, MemWrite        load / store
//   RegWrite, MemtoReg       writeback control carried into MEM/WB
//   Funct3                   access size and sign
//   ALUResult                effective address or plain ALU result
//   StoreData                forwarded rs2 for stores
//   Rd_in                    destination register
//   dmem_rdata, dmem_ack     memory response
//   dmem_req, dmem_we        registered request (held until ack)
//   dmem_addr                word-aligned address
//   dmem_wdata, dmem_wstrb   lane-replicated store data and byte enables
//   stall                    upstream hold (combinational)
//   mem_fault, fault_cause   one-cycle fault pulse; cause 01 misaligned, 10 timeout, 11 illegal
//   MEM_WB_*                 registered writeback slot
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic        stall,
    output logic        mem_fault,
    output logic [1:0]  fault_cause,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg,
    output logic [4:0]  MEM_WB_Rd,
    output logic [31:0] MEM_WB_Data
);

    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_t;

    state_t          r_state;
    logic [CntW-1:0] r_cnt;

    // Copies of the access attributes taken at request time; the upstream slot is not
    // re-sampled while the access is in flight.
    logic [2:0]      r_f3;
    logic [1:0]      r_lane;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic            r_memtoreg;
    logic            r_is_load;

    logic            w_mem_op;
    logic            w_legal;
    logic            w_misaligned;
    logic            w_start;
    logic            w_timeout;
    logic [31:0]     w_st_wdata;
    logic [3:0]      w_st_wstrb;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load_data;

    assign w_mem_op  = in_valid & (MemRead | MemWrite);
    assign w_start   = w_mem_op & w_legal & ~w_misaligned;
    assign w_timeout = (r_cnt == LastCnt);

    // In ACCESS the timeout cycle releases the pipeline just like an ack does.
    assign stall = (r_state == StIdle) ? w_start : (~dmem_ack & ~w_timeout);

    // Funct3 legality and natural alignment of the current slot.
    always_comb begin
        w_legal = 1'b0;
        if (MemRead) begin
            case (Funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end else begin
            case (Funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                default:                w_legal = 1'b0;
            endcase
        end

        case (Funct3[1:0])
            2'b01:   w_misaligned = ALUResult[0];
            2'b10:   w_misaligned = |ALUResult[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Store lane steering: data is replicated so every enabled lane sees the right bytes.
    always_comb begin
        case (Funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{StoreData[7:0]}};
                w_st_wstrb = 4'b0001 << ALUResult[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{StoreData[15:0]}};
                w_st_wstrb = 4'b0011 << {ALUResult[1], 1'b0};
            end
            default: begin
                w_st_wdata = StoreData;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load extraction from the latched lane and size.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (r_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_f3            <= '0;
            r_lane          <= '0;
            r_rd            <= '0;
            r_regwrite      <= 1'b0;
            r_memtoreg      <= 1'b0;
            r_is_load       <= 1'b0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_wstrb      <= '0;
            mem_fault       <= 1'b0;
            fault_cause     <= '0;
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_MemtoReg <= 1'b0;
            MEM_WB_Rd       <= '0;
            MEM_WB_Data     <= '0;
        end else begin
            mem_fault <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_mem_op) begin
                        // Any memory op leaves a bubble here; its result arrives on ack.
                        MEM_WB_RegWrite <= 1'b0;
                        MEM_WB_MemtoReg <= 1'b0;
                        MEM_WB_Rd       <= '0;
                        if (!w_legal) begin
                            mem_fault   <= 1'b1;
                            fault_cause <= 2'b11;
                        end else if (w_misaligned) begin
                            mem_fault   <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            r_state    <= StAccess;
                            r_cnt      <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ~MemRead;
                            dmem_addr  <= {ALUResult[31:2], 2'b00};
                            dmem_wdata <= MemRead ? 32'd0 : w_st_wdata;
                            dmem_wstrb <= MemRead ? 4'd0 : w_st_wstrb;
                            r_f3       <= Funct3;
                            r_lane     <= ALUResult[1:0];
                            r_rd       <= Rd_in;
                            r_regwrite <= RegWrite;
                            r_memtoreg <= MemtoReg;
                            r_is_load  <= MemRead;
                        end
                    end else begin
                        MEM_WB_RegWrite <= in_valid & RegWrite;
                        MEM_WB_MemtoReg <= in_valid & MemtoReg;
                        MEM_WB_Rd       <= in_valid ? Rd_in : 5'd0;
                        MEM_WB_Data     <= ALUResult;
                    end
                end
                StAccess: begin
                    if (dmem_ack) begin
                        r_state         <= StIdle;
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        dmem_wstrb      <= '0;
                        MEM_WB_RegWrite <= r_regwrite & r_is_load;
                        MEM_WB_MemtoReg <= r_memtoreg;
                        MEM_WB_Rd       <= r_rd;
                        if (r_is_load) begin
                            MEM_WB_Data <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_state         <= StIdle;
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        dmem_wstrb      <= '0;
                        mem_fault       <= 1'b1;
                        fault_cause     <= 2'b10;
                        MEM_WB_RegWrite <= 1'b0;
                        MEM_WB_MemtoReg <= 1'b0;
                        MEM_WB_Rd       <= '0;
                    end else begin
                        r_cnt           <= r_cnt + 1'b1;
                        MEM_WB_RegWrite <= 1'b0;
                        MEM_WB_MemtoReg <= 1'b0;
                        MEM_WB_Rd       <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
